// File: rtl/fp16_reduce_seq_if.sv
// Handshake and configuration bundle for the fp16 sequential reducer.
// The slave modport is the reducer's view; master is the producer/consumer side.
interface fp16_reduce_seq_if;
    localparam int floatControlWidth = 1;

    logic [floatControlWidth-1:0] control;
    logic [2:0]                   roundingMode;
    logic                         in_valid;
    logic                         in_ready;
    logic [15:0]                  in_data;
    logic                         in_sub;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [15:0]                  out_data;
    logic [4:0]                   out_flags;
    logic [7:0]                   out_count;
    logic                         busy;

    modport master (
        output control, roundingMode, in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_flags, out_count, busy
    );

    modport slave (
        input  control, roundingMode, in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_data, out_flags, out_count, busy
    );
endinterface

// File: rtl/fp16_reduce_seq.sv
// Sequential fp16 reducer: collects up to three operands per group and folds
// them into an accumulator with a single four-input adder.
module Adder_module (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [2:0]  subOp,
    input  logic [0:0]  control,
    input  logic [2:0]  roundingMode,
    output logic [15:0] out,
    output logic [4:0]  exceptionFlags
);
    logic [15:0] w_op [4];
    logic [43:0] w_sum, w_mag;
    logic        w_neg, w_nan, w_snan, w_pinf, w_ninf, w_allneg;
    logic [5:0]  w_p, w_sh;
    logic [16:0] w_pre, w_rnd;
    logic        w_g, w_s, w_inc, w_inx, w_ovf, w_unf, w_toinf;

    // Every finite fp16 is an exact multiple of 2^-24, so the four-term sum is
    // formed exactly in fixed point and rounded once.
    function automatic logic [43:0] to_fixed(input logic [15:0] x);
        logic [39:0] mag;
        if (x[14:10] == 5'd0) mag = {30'd0, x[9:0]};
        else                  mag = {29'd0, 1'b1, x[9:0]} << (x[14:10] - 5'd1);
        return x[15] ? (44'd0 - {4'd0, mag}) : {4'd0, mag};
    endfunction

    assign w_op[0] = a;
    assign w_op[1] = {b[15] ^ subOp[2], b[14:0]};
    assign w_op[2] = {c[15] ^ subOp[1], c[14:0]};
    assign w_op[3] = {d[15] ^ subOp[0], d[14:0]};

    always_comb begin
        w_sum    = '0;
        w_nan    = 1'b0;
        w_snan   = 1'b0;
        w_pinf   = 1'b0;
        w_ninf   = 1'b0;
        w_allneg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_sum    = w_sum + to_fixed(w_op[i]);
            w_allneg = w_allneg & w_op[i][15];
            if (w_op[i][14:10] == 5'h1F) begin
                if (w_op[i][9:0] != 10'd0) begin
                    w_nan  = 1'b1;
                    w_snan = w_snan | ~w_op[i][9];
                end else if (w_op[i][15]) w_ninf = 1'b1;
                else                      w_pinf = 1'b1;
            end
        end
        w_neg = w_sum[43];
        w_mag = w_neg ? (44'd0 - w_sum) : w_sum;
        w_p   = 6'd0;
        for (int i = 0; i < 44; i++) if (w_mag[i]) w_p = 6'(i);
        w_sh = w_p - 6'd10;
        w_g  = 1'b0;
        w_s  = 1'b0;
        if (w_mag < 44'd2048) w_pre = {2'b00, w_mag[14:0]};
        else begin
            w_pre = {1'b0, w_p - 6'd9, 10'(w_mag >> w_sh)};
            w_g   = w_mag[w_sh - 6'd1];
            w_s   = |(w_mag & ((44'd1 << (w_sh - 6'd1)) - 44'd1));
        end
        case (roundingMode)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = w_neg & (w_g | w_s);
            3'd3:    w_inc = ~w_neg & (w_g | w_s);
            3'd4:    w_inc = w_g;
            default: w_inc = w_g & (w_s | w_pre[0]);
        endcase
        w_rnd   = w_pre + {16'd0, w_inc};
        w_inx   = w_g | w_s;
        w_ovf   = w_rnd >= 17'h07C00;
        w_unf   = w_inx & (control[0] ? (w_rnd < 17'h00400) : (w_mag < 44'd1024));
        w_toinf = (roundingMode == 3'd2) ? w_neg :
                  (roundingMode == 3'd3) ? ~w_neg : (roundingMode != 3'd1);

        out            = {w_neg, w_rnd[14:0]};
        exceptionFlags = {2'b00, 1'b0, w_unf, w_inx};
        if (w_snan || (w_pinf && w_ninf)) begin
            out            = 16'h7E00;
            exceptionFlags = 5'b10000;
        end else if (w_nan) begin
            out            = 16'h7E00;
            exceptionFlags = 5'b00000;
        end else if (w_pinf || w_ninf) begin
            out            = {w_ninf, 15'h7C00};
            exceptionFlags = 5'b00000;
        end else if (w_ovf) begin
            out            = {w_neg, w_toinf ? 15'h7C00 : 15'h7BFF};
            exceptionFlags = {2'b00, 1'b1, w_unf, 1'b1};
        end else if (w_mag == 44'd0) begin
            out            = {w_allneg | (roundingMode == 3'd2), 15'd0};
            exceptionFlags = 5'b00000;
        end
    end
endmodule

// state     | meaning
// S_COLLECT | accept operands into slots 0..2
// S_ADD     | fold accumulator and slots through the adder, clear slots
// S_DONE    | present result until out_ready
module fp16_reduce_seq (
    input logic              clock,
    input logic              nReset,
    fp16_reduce_seq_if.slave bus
);
    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_ADD     = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]  r_state, r_fill;
    logic [15:0] r_slot [3];
    logic [2:0]  r_sub;
    logic [15:0] r_acc;
    logic [4:0]  r_flags;
    logic [7:0]  r_count;
    logic [0:0]  r_ctrl;
    logic [2:0]  r_rm;
    logic        r_first, r_grp_last, r_live;
    logic        w_xfer;
    logic [15:0] w_sum;
    logic [4:0]  w_exc;

    assign w_xfer        = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = r_live & (r_state == S_COLLECT);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = r_acc;
    assign bus.out_flags = r_flags;
    assign bus.out_count = r_count;
    assign bus.busy      = !((r_state == S_COLLECT) && (r_fill == 2'd0));

    Adder_module u_add (
        .a              (r_acc),
        .b              (r_slot[0]),
        .c              (r_slot[1]),
        .d              (r_slot[2]),
        .subOp          ({r_sub[0], r_sub[1], r_sub[2]}),
        .control        (r_ctrl),
        .roundingMode   (r_rm),
        .out            (w_sum),
        .exceptionFlags (w_exc)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state    <= S_COLLECT;
            r_fill     <= 2'd0;
            for (int i = 0; i < 3; i++) r_slot[i] <= 16'h0000;
            r_sub      <= 3'b000;
            r_acc      <= 16'h0000;
            r_flags    <= 5'd0;
            r_count    <= 8'd0;
            r_ctrl     <= 1'b0;
            r_rm       <= 3'd0;
            r_first    <= 1'b1;
            r_grp_last <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 3; i++) begin
                            if (r_fill == 2'(i)) begin
                                r_slot[i] <= bus.in_data;
                                r_sub[i]  <= bus.in_sub;
                            end
                        end
                        r_first <= 1'b0;
                        // A new reduction starts from a +0 seed with fresh settings.
                        if (r_first) begin
                            r_acc   <= 16'h0000;
                            r_flags <= 5'd0;
                            r_ctrl  <= bus.control;
                            r_rm    <= bus.roundingMode;
                            r_count <= 8'd1;
                        end else if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'd1;
                        end
                        if (bus.in_last || (r_fill == 2'd2)) begin
                            r_state    <= S_ADD;
                            r_fill     <= 2'd0;
                            r_grp_last <= bus.in_last;
                        end else begin
                            r_fill <= r_fill + 2'd1;
                        end
                    end
                end
                S_ADD: begin
                    r_acc   <= w_sum;
                    r_flags <= r_flags | w_exc;
                    for (int i = 0; i < 3; i++) r_slot[i] <= 16'h0000;
                    r_sub   <= 3'b000;
                    r_state <= r_grp_last ? S_DONE : S_COLLECT;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_COLLECT;
                        r_first <= 1'b1;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end
endmodule

// File: doc/fp16_reduce_seq.md
FP16_REDUCE_SEQ -- requirements
Module: fp16_reduce_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits (IEEE binary16).
REQ-002 The port `clock` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port `nReset` SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 The port `control` SHALL be an input, `floatControlWidth` bits wide: the HardFloat control word, sampled with the first operand of a reduction.
REQ-005 The port `roundingMode` SHALL be an input, 3 bits wide, sampled with the first operand of a reduction.
REQ-006 The port `in_valid` SHALL be an input, 1 bit wide: the operand offer.
REQ-007 The port `in_ready` SHALL be an output, 1 bit wide: the block accepts an operand.
REQ-008 The port `in_data` SHALL be an input, 16 bits wide: the fp16 operand.
REQ-009 The port `in_sub` SHALL be an input, 1 bit wide: subtract this operand instead of adding it.
REQ-010 The port `in_last` SHALL be an input, 1 bit wide: marks the final operand of the reduction.
REQ-011 The port `out_valid` SHALL be an output, 1 bit wide: the result is available.
REQ-012 The port `out_ready` SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-013 The port `out_data` SHALL be an output, 16 bits wide: the fp16 sum.
REQ-014 The port `out_flags` SHALL be an output, 5 bits wide: the OR of the adder exceptionFlags over the whole reduction.
REQ-015 The port `out_count` SHALL be an output, 8 bits wide: the number of operands accepted, saturating at 255.
REQ-016 The port `busy` SHALL be an output, 1 bit wide: high in any state other than COLLECT with 0 slots filled.

Function
REQ-017 The block SHALL instantiate exactly one Adder_module and drive it as follows: a = accumulator; b, c, d = slots 0, 1, 2; subOp = {sub0, sub1, sub2}.
REQ-018 The states SHALL be COLLECT, ADD and DONE.
REQ-019 COLLECT SHALL drive in_ready=1; a transfer occurs when in_valid && in_ready.
REQ-020 Each transfer SHALL write in_data and in_sub into the next free slot and increment out_count (saturating).
REQ-021 The first transfer after entry from DONE or reset SHALL also clear the accumulator to 0x0000 and flags to 0, and latch control and roundingMode.
REQ-022 A transfer that fills slot 2, or one with in_last=1, SHALL move the FSM to ADD on the next cycle; slots not filled in that group SHALL hold 0x0000 with sub=0.
REQ-023 ADD SHALL drive in_ready=0 and last one cycle.
REQ-024 In ADD, the accumulator SHALL be loaded with adder out, flags SHALL be OR-ed with exceptionFlags, and all slots SHALL be cleared to 0x0000 with sub=0.
REQ-025 Exit from ADD SHALL go to DONE if the group contained in_last, else to COLLECT.
REQ-026 DONE SHALL drive out_valid=1, out_data = accumulator and out_flags = flags, with in_ready=0.
REQ-027 In DONE, out_valid && out_ready SHALL return the FSM to COLLECT on the next cycle.
REQ-028 After the DONE handshake, out_data, out_flags and out_count SHALL keep their values until the next reduction's first transfer.
REQ-029 While out_ready=0 in DONE, all outputs SHALL be held stable.
REQ-030 Latency SHALL be: result valid 2 cycles after the in_last transfer; N operands take N transfer cycles plus ceil(N/3) ADD cycles.
REQ-031 The adder SHALL see stable inputs throughout ADD; the control and roundingMode ports SHALL be ignored except at the first transfer.
REQ-032 An all-negative-zero stream SHALL yield 0x0000 (the +0 accumulator seed wins).

Reset
REQ-033 On nReset=0, the FSM SHALL go to COLLECT with 0 slots filled, immediately and independent of clock.
REQ-034 On reset, the accumulator, slots, sub bits, flags, out_data and out_count SHALL be zero, and the latched control and roundingMode SHALL be zero.
REQ-035 On reset, outputs SHALL be out_valid=0, in_ready=0 and busy=0.
REQ-036 in_ready SHALL rise on the first clock edge after nReset deasserts.
REQ-037 Reset asserted mid-reduction SHALL discard all partial state; no out_valid SHALL follow.

Verification
REQ-038 Scenario 1: 0x3C00, then 0x3C00 (last), sub=0 -> out_data=0x4000, out_count=2, out_flags=0.
REQ-039 Scenario 2: 0x4880, 0x3C00, 0x3800, then 0x3400 (last) -> two ADD cycles, out_data=0x4960, out_count=4.
REQ-040 Scenario 3: 0x3C00, 0x4000 (sub), 0x4500, then 0x4B00 (sub, last) -> out_data=0xC900.
REQ-041 Scenario 4: single 0x3C00 (last) -> out_valid exactly 2 cycles after the transfer, out_data=0x3C00; then seven 0x3C00 operands with the last flagged -> 0x4700, out_count=7.
REQ-042 Scenario 5: Scenario 1 with out_ready held low 5 cycles -> out_valid and out_data=0x4000 stable, in_ready=0 throughout, and one handshake on release.
REQ-043 Scenario 6: nReset pulsed low after two transfers of a 4-operand stream -> out_valid never rises; a following stream of 0x4000 and 0x4000 (last) gives 0x4400 with out_count=2.
